// File: rtl/f_pool_collect_if.sv
// Result stream from the pool collector to the memory-writer stage.
//   out_valid : head entry present
//   out_ready : consumer takes the head this cycle
//   out_data  : head entry
interface f_pool_collect_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/f_pool_collect.sv
// Pool collector: follows the max-accumulator's stride/delay phase, captures
// each completed window maximum (plus the final window at end of stream),
// optionally applies float ReLU, and queues results in a small FIFO that
// drains over a valid/ready stream.
//   clk, rst_n       : clock, async active-low reset
//   run              : start pulse (reload phase, clear window/status state)
//   running          : accumulator is consuming data
//   strideMinusOne   : window length - 1
//   delay0           : initial phase delay
//   reluEnable       : negative captures become +0.0
//   in0              : accumulator running max
//   out_if           : result stream (master side)
//   windowsOut       : results popped since last run (wraps)
//   overflow         : sticky, a capture was dropped on a full FIFO
module f_pool_collect #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 7,
  parameter int DEPTH   = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               reluEnable,
  input  logic [DATA_W-1:0]  in0,
  f_pool_collect_if.master   out_if,
  output logic [15:0]        windowsOut,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DELAY_W-1:0]           delay_q, delay_d;
  logic                         primed_q, primed_d;
  logic                         running_q, running_d;
  logic [AW:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [15:0]                  win_q, win_d;
  logic                         ovf_q, ovf_d;

  logic              boundary, cap_eos, capture, empty, full, push, pop;
  logic [DATA_W-1:0] cap_val;

  always_comb begin
    boundary = (delay_q == '0);
    // run suppresses both capture paths; on a boundary in0 still holds
    // the previous window's max
    cap_eos  = !run && running_q && !running && primed_q;
    capture  = (!run && boundary && running && primed_q) || cap_eos;
    // sign bit set covers -0.0 as well
    cap_val  = (reluEnable && in0[DATA_W-1]) ? '0 : in0;

    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop   = !empty && out_if.out_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    push  = capture && (!full || pop);

    if (run)                 delay_d = delay0;
    else if (delay_q != '0)  delay_d = delay_q - 1'b1;
    else                     delay_d = strideMinusOne;

    if (run || cap_eos)             primed_d = 1'b0;
    else if (boundary && running)   primed_d = 1'b1;
    else                            primed_d = primed_q;

    running_d = running;

    mem_d = mem_q;
    if (push) mem_d[wptr_q[AW-1:0]] = cap_val;
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};

    // run takes priority over a same-cycle pop for the window count
    if (run)      win_d = '0;
    else if (pop) win_d = win_q + 16'd1;
    else          win_d = win_q;

    if (run)                          ovf_d = 1'b0;
    else if (capture && full && !pop) ovf_d = 1'b1;
    else                              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q   <= '0;
      primed_q  <= 1'b0;
      running_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_q     <= '0;
      win_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      delay_q   <= delay_d;
      primed_q  <= primed_d;
      running_q <= running_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_q     <= mem_d;
      win_q     <= win_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_if.out_valid = !empty;
  assign out_if.out_data  = mem_q[rptr_q[AW-1:0]];
  assign windowsOut       = win_q;
  assign overflow         = ovf_q;
endmodule

// File: tb/tb_f_pool_collect.sv
// Directed bench for f_pool_collect. Inputs change 1ns after the rising
// edge; outputs are checked on the falling edge of the same cycle.
module tb_f_pool_collect;
  localparam int DATA_W = 32, DELAY_W = 7, DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run, running, reluEnable;
  logic [DELAY_W-1:0] strideMinusOne, delay0;
  logic [DATA_W-1:0]  in0;
  logic [15:0]        windowsOut;
  logic               overflow;

  f_pool_collect_if #(.DATA_W(DATA_W)) bus ();

  f_pool_collect #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .running(running),
    .strideMinusOne(strideMinusOne), .delay0(delay0), .reluEnable(reluEnable),
    .in0(in0), .out_if(bus), .windowsOut(windowsOut), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one clock cycle: new inputs just after the edge, then on to the check point
  task automatic cyc(input logic r, input logic rn, input logic [31:0] d, input logic rdy);
    @(posedge clk); #1;
    run = r; running = rn; in0 = d; bus.out_ready = rdy;
    @(negedge clk);
  endtask

  // stride 3, boundaries at cycles 1,4,7; end-of-stream capture at 10
  task automatic stream(input logic relu, input logic [31:0] v4, v7, v10,
                        input logic [31:0] e0, e1, e2);
    logic [31:0] d;
    logic ev;
    strideMinusOne = 7'd2; delay0 = 7'd0; reluEnable = relu;
    for (int c = 0; c < 14; c++) begin
      d = (c == 4) ? v4 : (c == 7) ? v7 : (c == 10) ? v10 : 32'h4100_0000 + c;
      cyc(c == 0, (c >= 1) && (c <= 9), d, 1'b1);
      ev = (c == 5) || (c == 8) || (c == 11);
      chk("str_vld", {31'd0, bus.out_valid}, {31'd0, ev});
      if (ev) chk("str_data", bus.out_data, (c == 5) ? e0 : (c == 8) ? e1 : e2);
    end
    chk("str_wins", {16'd0, windowsOut}, 32'd3);
  endtask

  logic [31:0] fv [6]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                           32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
  logic [31:0] av [5]  = '{32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
                           32'h4140_0000, 32'h4150_0000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; run = 0; running = 0; in0 = '0; reluEnable = 0;
    strideMinusOne = '0; delay0 = '0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_vld",  {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_wins", {16'd0, windowsOut}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    #1 rst_n = 1'b1;

    // basic stream, then the same stream through ReLU
    stream(1'b0, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000,
                 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000);
    stream(1'b1, 32'h4040_0000, 32'hC000_0000, 32'h8000_0000,
                 32'h4040_0000, 32'h0000_0000, 32'h0000_0000);

    // backpressure: 5 boundary captures + 1 end-of-stream capture, no ready
    strideMinusOne = 7'd0; delay0 = 7'd0; reluEnable = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);                       // first boundary only primes
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, fv[i], 0);
      chk("bp_ovf_pre", {31'd0, overflow}, 32'd0);
    end
    cyc(0, 0, fv[5], 0);                   // 5th capture was dropped
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      chk("bp_vld",  {31'd0, bus.out_valid}, 32'd1);
      chk("bp_data", bus.out_data, fv[i]);
    end
    cyc(0, 0, 0, 1);
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_wins",  {16'd0, windowsOut}, 32'd4);
    chk("bp_ovf_sticky", {31'd0, overflow}, 32'd1);

    // full FIFO with a capture in the same cycle as a pop
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("fp_ovf_clr", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, av[i], 0);
    cyc(0, 0, av[4], 1);                   // end-of-stream capture + pop
    chk("fp_head", bus.out_data, av[0]);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      chk("fp_data", bus.out_data, av[i]);
      chk("fp_ovf",  {31'd0, overflow}, 32'd0);
    end
    cyc(0, 0, 0, 1);
    chk("fp_empty", {31'd0, bus.out_valid}, 32'd0);

    // delay/priming: counter 5,4,3,2,1 over cycles 1-5, boundary at 6
    // (primes), next boundary at 10 (first capture). run at 11 beats the
    // running fall, so nothing further is captured.
    delay0 = 7'd5; strideMinusOne = 7'd3;
    for (int c = 0; c < 13; c++) begin
      d = (c[0] ? 32'hC000_0000 : 32'h4000_0000) | c;
      cyc((c == 0) || (c == 11), (c >= 1) && (c <= 10), d, 1'b1);
      chk("dp_vld", {31'd0, bus.out_valid}, {31'd0, c == 11});
      if (c == 11) chk("dp_data", bus.out_data, 32'h4000_000A);
    end

    // reset mid-stream with 2 entries queued and overflow set
    strideMinusOne = 7'd0; delay0 = 7'd0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, fv[i], 0);
    cyc(0, 0, fv[4], 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("mr_pre_ovf",  {31'd0, overflow}, 32'd1);
    chk("mr_pre_wins", {16'd0, windowsOut}, 32'd2);
    chk("mr_pre_data", bus.out_data, fv[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_vld",  {31'd0, bus.out_valid}, 32'd0);
    chk("mr_ovf",  {31'd0, overflow}, 32'd0);
    chk("mr_wins", {16'd0, windowsOut}, 32'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(0, 0, 32'h4000_0000 + c, 1);
      chk("mr_idle", {31'd0, bus.out_valid}, 32'd0);
    end
    strideMinusOne = 7'd1;
    cyc(1, 0, 32'h4200_0000, 1);
    cyc(0, 1, 32'h4200_0001, 1);           // boundary: primes
    chk("mr_b1", {31'd0, bus.out_valid}, 32'd0);
    cyc(0, 1, 32'h4200_0002, 1);
    chk("mr_b2", {31'd0, bus.out_valid}, 32'd0);
    cyc(0, 1, 32'h4200_0003, 1);           // boundary: capture
    chk("mr_b3", {31'd0, bus.out_valid}, 32'd0);
    cyc(0, 0, 32'h4200_0004, 1);           // end-of-stream capture
    chk("mr_cap_vld",  {31'd0, bus.out_valid}, 32'd1);
    chk("mr_cap_data", bus.out_data, 32'h4200_0003);
    cyc(0, 0, 0, 1);
    chk("mr_eos_data", bus.out_data, 32'h4200_0004);
    cyc(0, 0, 0, 1);
    chk("mr_done", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
